// File: rtl/id_stage_pipe.sv
// id_stage_pipe: handshaked MIPS decode stage holding IF/ID, ID/EX and the register file.
// Optional feature macro ID_BYPASS_EN: writeback data is written through to same-cycle ID reads.
module id_stage_pipe #(
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned REG_NUM = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [31:0]       in_instr,
   input  logic [31:0]       in_pc,
   input  logic [4:0]        in_exc,
   input  logic              hz_stall,
   input  logic              flush,
   input  logic              fwd_rs_en,
   input  logic              fwd_rt_en,
   input  logic [DATA_W-1:0] fwd_rs_data,
   input  logic [DATA_W-1:0] fwd_rt_data,
   input  logic              wb_we,
   input  logic [4:0]        wb_addr,
   input  logic [DATA_W-1:0] wb_data,
   output logic              redirect,
   output logic [31:0]       redirect_pc,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_instr,
   output logic [31:0]       out_pc,
   output logic [DATA_W-1:0] out_rs_data,
   output logic [DATA_W-1:0] out_rt_data,
   output logic [DATA_W-1:0] out_imm,
   output logic [4:0]        out_exc
);

   localparam int unsigned AW = (REG_NUM > 1) ? $clog2(REG_NUM) : 1;
   localparam logic [4:0] EXC_RI = 5'd10;

   logic              id_valid_q;
   logic [31:0]       id_instr_q, id_pc_q;
   logic [4:0]        id_exc_q;
   logic              out_valid_q;
   logic [31:0]       out_instr_q, out_pc_q;
   logic [DATA_W-1:0] out_rs_q, out_rt_q, out_imm_q;
   logic [4:0]        out_exc_q;
   logic [DATA_W-1:0] rf_q [REG_NUM];

   logic              advance, legal, kill, taken;
   logic [5:0]        op, dec_op;
   logic [31:0]       dec_instr, pc_plus4, br_target, target;
   logic [4:0]        dec_exc, rs_addr, rt_addr;
   logic [15:0]       imm16;
   logic [DATA_W-1:0] rs_rf, rt_rf, rs_val, rt_val, imm;

   // Faulted or undefined instructions travel down the pipe as an all-zero nop.
   always_comb begin
      op        = id_instr_q[31:26];
      legal     = op inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07, 6'h08, 6'h09,
                             6'h0a, 6'h0c, 6'h0d, 6'h0e, 6'h0f, 6'h23, 6'h2b};
      kill      = (id_exc_q != 5'd0) || !legal;
      dec_instr = kill ? 32'h0 : id_instr_q;
      dec_exc   = (id_exc_q != 5'd0) ? id_exc_q : (legal ? 5'd0 : EXC_RI);
      dec_op    = dec_instr[31:26];
      rs_addr   = dec_instr[25:21];
      rt_addr   = dec_instr[20:16];
      imm16     = dec_instr[15:0];
   end

   always_comb begin
      rs_rf = '0;
      rt_rf = '0;
      if (rs_addr != 5'd0 && 32'(rs_addr) < REG_NUM) rs_rf = rf_q[rs_addr[AW-1:0]];
      if (rt_addr != 5'd0 && 32'(rt_addr) < REG_NUM) rt_rf = rf_q[rt_addr[AW-1:0]];
`ifdef ID_BYPASS_EN
      if (wb_we && wb_addr == rs_addr && rs_addr != 5'd0 && 32'(rs_addr) < REG_NUM)
         rs_rf = wb_data;
      if (wb_we && wb_addr == rt_addr && rt_addr != 5'd0 && 32'(rt_addr) < REG_NUM)
         rt_rf = wb_data;
`endif
      rs_val = fwd_rs_en ? fwd_rs_data : rs_rf;
      rt_val = fwd_rt_en ? fwd_rt_data : rt_rf;
   end

   always_comb begin
      case (dec_op)
         6'h0c, 6'h0d, 6'h0e: imm = DATA_W'(imm16);
         6'h0f:               imm = DATA_W'(signed'({imm16, 16'h0000}));
         default:             imm = DATA_W'(signed'(imm16));
      endcase
   end

   always_comb begin
      pc_plus4  = id_pc_q + 32'd4;
      br_target = pc_plus4 + {{14{imm16[15]}}, imm16, 2'b00};
      taken     = 1'b0;
      target    = br_target;
      case (dec_op)
         6'h00: begin
            if (dec_instr[5:0] == 6'b001000) begin
               taken  = 1'b1;
               target = rs_val[31:0];
            end
         end
         6'h02, 6'h03: begin
            taken  = 1'b1;
            target = {pc_plus4[31:28], dec_instr[25:0], 2'b00};
         end
         6'h04: taken = (rs_val == rt_val);
         6'h05: taken = (rs_val != rt_val);
         6'h06: taken = rs_val[DATA_W-1] || (rs_val == '0);
         6'h07: taken = !rs_val[DATA_W-1] && (rs_val != '0);
         default: ;
      endcase
   end

   assign advance     = id_valid_q & ~hz_stall & (~out_valid_q | out_ready);
   assign in_ready    = ~id_valid_q | advance;
   assign redirect    = advance & taken & ~flush;
   assign redirect_pc = target;

   always_ff @(posedge clk) begin
      if (reset) begin
         id_valid_q  <= 1'b0;
         id_instr_q  <= '0;
         id_pc_q     <= '0;
         id_exc_q    <= '0;
         out_valid_q <= 1'b0;
         out_instr_q <= '0;
         out_pc_q    <= '0;
         out_rs_q    <= '0;
         out_rt_q    <= '0;
         out_imm_q   <= '0;
         out_exc_q   <= '0;
         for (int unsigned i = 0; i < REG_NUM; i++) rf_q[i] <= '0;
      end else begin
         if (flush) begin
            id_valid_q <= 1'b0;
         end else if (in_valid && in_ready) begin
            id_valid_q <= 1'b1;
            id_instr_q <= in_instr;
            id_pc_q    <= in_pc;
            id_exc_q   <= in_exc;
         end else if (advance) begin
            id_valid_q <= 1'b0;
         end

         if (flush) begin
            out_valid_q <= 1'b0;
         end else if (advance) begin
            out_valid_q <= 1'b1;
            out_instr_q <= dec_instr;
            out_pc_q    <= id_pc_q;
            out_rs_q    <= rs_val;
            out_rt_q    <= rt_val;
            out_imm_q   <= imm;
            out_exc_q   <= dec_exc;
         end else if (out_ready && out_valid_q) begin
            out_valid_q <= 1'b0;
         end

         // Writeback proceeds even while flushing.
         if (wb_we && wb_addr != 5'd0 && 32'(wb_addr) < REG_NUM)
            rf_q[wb_addr[AW-1:0]] <= wb_data;
      end
   end

   assign out_valid   = out_valid_q;
   assign out_instr   = out_instr_q;
   assign out_pc      = out_pc_q;
   assign out_rs_data = out_rs_q;
   assign out_rt_data = out_rt_q;
   assign out_imm     = out_imm_q;
   assign out_exc     = out_exc_q;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Randomized scoreboard bench for id_stage_pipe against a transaction-level reference model.
// Built with or without ID_BYPASS_EN; the model follows the same macro.
module tb_id_stage_pipe;

   localparam int unsigned DW = 32;
   localparam int unsigned RN = 16;

   logic          clk = 1'b0;
   logic          reset;
   logic          in_valid, in_ready;
   logic [31:0]   in_instr, in_pc;
   logic [4:0]    in_exc;
   logic          hz_stall, flush;
   logic          fwd_rs_en, fwd_rt_en;
   logic [DW-1:0] fwd_rs_data, fwd_rt_data;
   logic          wb_we;
   logic [4:0]    wb_addr;
   logic [DW-1:0] wb_data;
   logic          redirect;
   logic [31:0]   redirect_pc;
   logic          out_valid, out_ready;
   logic [31:0]   out_instr, out_pc;
   logic [DW-1:0] out_rs_data, out_rt_data, out_imm;
   logic [4:0]    out_exc;

   id_stage_pipe #(.DATA_W(DW), .REG_NUM(RN)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
      .in_exc(in_exc), .hz_stall(hz_stall), .flush(flush),
      .fwd_rs_en(fwd_rs_en), .fwd_rt_en(fwd_rt_en),
      .fwd_rs_data(fwd_rs_data), .fwd_rt_data(fwd_rt_data),
      .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
      .redirect(redirect), .redirect_pc(redirect_pc),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_instr(out_instr), .out_pc(out_pc),
      .out_rs_data(out_rs_data), .out_rt_data(out_rt_data),
      .out_imm(out_imm), .out_exc(out_exc)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
      logic [4:0]  exc;
   } if_t;

   typedef struct packed {
      logic [31:0]   instr;
      logic [31:0]   pc;
      logic [DW-1:0] rs;
      logic [DW-1:0] rt;
      logic [DW-1:0] imm;
      logic [4:0]    exc;
   } out_t;

   localparam logic [5:0] OPS [20] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07,
      6'h08, 6'h09, 6'h0a, 6'h0c, 6'h0d, 6'h0e, 6'h0f, 6'h23, 6'h2b, 6'h01, 6'h0b, 6'h3f,
      6'h00};

   if_t           id_q [$];
   out_t          exp_q [$];
   logic [DW-1:0] ref_rf [32];
   int            n_vec = 0;
   int            n_bad = 0;
   bit            run = 1'b0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      n_vec++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, req, $time);
      end
   endtask

   function automatic bit is_legal(input logic [5:0] op);
      return op inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07, 6'h08, 6'h09,
                        6'h0a, 6'h0c, 6'h0d, 6'h0e, 6'h0f, 6'h23, 6'h2b};
   endfunction

   function automatic logic [DW-1:0] rd(input logic [4:0] a);
      if (a == 5'd0 || a >= RN) return '0;
`ifdef ID_BYPASS_EN
      if (wb_we && wb_addr == a) return wb_data;
`endif
      return ref_rf[a];
   endfunction

   // Architectural meaning of the instruction sitting in ID, given this cycle's inputs.
   task automatic model(input if_t f, output out_t o, output bit tk, output logic [31:0] tgt);
      logic [31:0] ins, nxt;
      logic [15:0] i16;
      logic [5:0]  op;
      logic signed [DW-1:0] a;
      logic [DW-1:0] b;
      bit ok;
      ok      = is_legal(f.instr[31:26]);
      ins     = (f.exc != 0 || !ok) ? 32'h0 : f.instr;
      o.instr = ins;
      o.pc    = f.pc;
      o.exc   = (f.exc != 0) ? f.exc : (ok ? 5'd0 : 5'd10);
      a       = fwd_rs_en ? fwd_rs_data : rd(ins[25:21]);
      b       = fwd_rt_en ? fwd_rt_data : rd(ins[20:16]);
      o.rs    = a;
      o.rt    = b;
      op      = ins[31:26];
      i16     = ins[15:0];
      if (op == 6'h0c || op == 6'h0d || op == 6'h0e) o.imm = {16'h0, i16};
      else if (op == 6'h0f)                          o.imm = {i16, 16'h0};
      else                                           o.imm = {{16{i16[15]}}, i16};
      nxt = f.pc + 32'd4;
      tk  = 1'b0;
      tgt = nxt + ({{16{i16[15]}}, i16} * 4);
      case (op)
         6'h04: tk = (a == b);
         6'h05: tk = (a != b);
         6'h06: tk = (a <= 0);
         6'h07: tk = (a > 0);
         6'h02, 6'h03: begin
            tk  = 1'b1;
            tgt = (nxt & 32'hf000_0000) | (ins[25:0] * 4);
         end
         6'h00: if (ins[5:0] == 6'h08) begin
            tk  = 1'b1;
            tgt = a[31:0];
         end
         default: ;
      endcase
   endtask

   // One clock: called at a falling edge with this cycle's inputs already applied.
   task automatic step(input bit cc, input bit c_redir, input logic [31:0] c_pc);
      out_t o;
      bit   mv, adv, tk, acc, er;
      logic [31:0] tgt;
      o   = '0;
      tk  = 1'b0;
      tgt = '0;
      #1;
      mv  = exp_q.size() != 0;
      adv = id_q.size() != 0 && !hz_stall && (!mv || out_ready);
      if (id_q.size() != 0) model(id_q[0], o, tk, tgt);
      er  = adv && tk && !flush;
      chk("out_valid", 64'(out_valid), 64'(mv));
      chk("in_ready", 64'(in_ready), 64'(id_q.size() == 0 || adv));
      chk("redirect", 64'(redirect), 64'(er));
      if (er) chk("redirect_pc", 64'(redirect_pc), 64'(tgt));
      if (cc) begin
         chk("dir_redirect", 64'(redirect), 64'(c_redir));
         if (c_redir) chk("dir_redirect_pc", 64'(redirect_pc), 64'(c_pc));
      end
      #2;
      acc = in_valid && (id_q.size() == 0 || adv);
      if (flush) begin
         exp_q.delete();
         id_q.delete();
      end else begin
         if (adv) begin
            exp_q.push_back(o);
            id_q.delete();
         end
         if (acc) id_q.push_back('{instr: in_instr, pc: in_pc, exc: in_exc});
      end
      if (wb_we && wb_addr != 0 && wb_addr < RN) ref_rf[wb_addr] = wb_data;
      @(negedge clk);
   endtask

   // Checks whatever ID/EX presents; retires the entry on a handshake.
   always begin
      @(negedge clk);
      #2;
      if (run && out_valid) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_out_valid", 64'(out_valid), 64'(0));
         end else begin
            chk("out_instr", 64'(out_instr), 64'(exp_q[0].instr));
            chk("out_pc", 64'(out_pc), 64'(exp_q[0].pc));
            chk("out_rs_data", 64'(out_rs_data), 64'(exp_q[0].rs));
            chk("out_rt_data", 64'(out_rt_data), 64'(exp_q[0].rt));
            chk("out_imm", 64'(out_imm), 64'(exp_q[0].imm));
            chk("out_exc", 64'(out_exc), 64'(exp_q[0].exc));
            if (out_ready) void'(exp_q.pop_front());
         end
      end
   end

   task automatic idle();
      in_valid = 0; in_instr = '0; in_pc = '0; in_exc = '0;
      hz_stall = 0; flush = 0; fwd_rs_en = 0; fwd_rt_en = 0;
      fwd_rs_data = '0; fwd_rt_data = '0;
      wb_we = 0; wb_addr = '0; wb_data = '0; out_ready = 1;
   endtask

   task automatic clear_model();
      id_q.delete();
      exp_q.delete();
      for (int i = 0; i < 32; i++) ref_rf[i] = '0;
   endtask

   task automatic chk_reset_state();
      chk("rst_out_valid", 64'(out_valid), 64'(0));
      chk("rst_in_ready", 64'(in_ready), 64'(1));
      chk("rst_redirect", 64'(redirect), 64'(0));
      chk("rst_out_instr", 64'(out_instr), 64'(0));
      chk("rst_out_pc", 64'(out_pc), 64'(0));
      chk("rst_out_rs", 64'(out_rs_data), 64'(0));
      chk("rst_out_rt", 64'(out_rt_data), 64'(0));
      chk("rst_out_imm", 64'(out_imm), 64'(0));
      chk("rst_out_exc", 64'(out_exc), 64'(0));
   endtask

   function automatic logic [31:0] rdata();
      case ($urandom_range(0, 3))
         0: return 32'h0;
         1: return 32'($urandom_range(0, 3));
         2: return 32'hffff_ffff;
         default: return $urandom();
      endcase
   endfunction

   function automatic logic [31:0] rand_instr();
      logic [31:0] r;
      r = $urandom();
      r[31:26] = OPS[$urandom_range(0, 19)];
      if ($urandom_range(0, 1) == 1) r[25:21] = 5'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) r[20:16] = 5'($urandom_range(0, 3));
      if (r[31:26] == 6'h00 && $urandom_range(0, 1) == 1) r[5:0] = 6'h08;
      return r;
   endfunction

   initial begin
      idle();
      clear_model();
      reset = 1;
      repeat (3) @(negedge clk);
      chk_reset_state();
      reset = 0;
      run = 1;

      // addiu $1,$0,5 then ori $2,$0,0xFFFF back to back
      in_valid = 1; in_instr = 32'h2401_0005; in_pc = 32'h1000; step(0, 0, 0);
      in_instr = 32'h3402_ffff; in_pc = 32'h1004; step(0, 0, 0);
      in_valid = 0;
      chk("addiu_imm", 64'(out_imm), 64'h5);
      chk("addiu_valid", 64'(out_valid), 64'h1);
      step(0, 0, 0);
      chk("ori_imm", 64'(out_imm), 64'hffff);
      chk("ori_valid", 64'(out_valid), 64'h1);
      step(0, 0, 0);

      // beq / bne with both operands forwarded as 7
      in_valid = 1; in_instr = 32'h1022_0004; in_pc = 32'h3000; step(0, 0, 0);
      in_valid = 1; in_instr = 32'h1422_0004; in_pc = 32'h3000;
      fwd_rs_en = 1; fwd_rt_en = 1; fwd_rs_data = 7; fwd_rt_data = 7;
      step(1, 1, 32'h3014);
      in_valid = 0; step(1, 0, 0);
      idle(); step(0, 0, 0);

      // EX back-pressure with both stages occupied
      out_ready = 0;
      in_valid = 1; in_instr = 32'h2401_0011; in_pc = 32'h5000; step(0, 0, 0);
      in_instr = 32'h2402_0022; in_pc = 32'h5004; step(0, 0, 0);
      chk("full_in_ready", 64'(in_ready), 64'h0);
      in_instr = 32'h2403_0033; in_pc = 32'h5008;
      repeat (3) step(0, 0, 0);
      out_ready = 1; step(0, 0, 0);
      in_valid = 0; repeat (3) step(0, 0, 0);

      // jr $31 held by the hazard unit
      in_valid = 1; in_instr = 32'h03e0_0008; in_pc = 32'h2000; step(0, 0, 0);
      in_valid = 0; hz_stall = 1; fwd_rs_en = 1; fwd_rs_data = 32'h3400;
      step(1, 0, 0);
      step(1, 0, 0);
      hz_stall = 0; step(1, 1, 32'h3400);
      idle(); step(0, 0, 0);

      // undefined opcode, then a fetch fault on the same word
      in_valid = 1; in_instr = 32'hfc00_0000; in_pc = 32'h6000; in_exc = 0; step(0, 0, 0);
      in_exc = 4; in_pc = 32'h6004; step(0, 0, 0);
      in_valid = 0; in_exc = 0;
      chk("undef_exc", 64'(out_exc), 64'd10);
      step(0, 0, 0);
      chk("ifexc_exc", 64'(out_exc), 64'd4);
      step(0, 0, 0);

      // writeback to $3 in the same cycle ID reads it
      in_valid = 1; in_instr = 32'h2465_0000; in_pc = 32'h4000; step(0, 0, 0);
      in_valid = 0; wb_we = 1; wb_addr = 3; wb_data = 32'hdead; step(0, 0, 0);
`ifdef ID_BYPASS_EN
      chk("wb_same_cycle", 64'(out_rs_data), 64'hdead);
`else
      chk("wb_same_cycle", 64'(out_rs_data), 64'h0);
`endif
      in_valid = 1; in_instr = 32'h2405_0000; wb_addr = 0; wb_data = 32'h1234; step(0, 0, 0);
      in_instr = 32'h2465_0000; wb_we = 0; step(0, 0, 0);
      in_valid = 0;
      chk("r0_reads_zero", 64'(out_rs_data), 64'h0);
      step(0, 0, 0);
      chk("r3_written", 64'(out_rs_data), 64'hdead);
      step(0, 0, 0);

      // randomized traffic
      for (int n = 0; n < 3000; n++) begin
         in_valid    = $urandom_range(0, 3) != 0;
         in_instr    = rand_instr();
         in_pc       = $urandom() & 32'hffff_fffc;
         in_exc      = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
         hz_stall    = $urandom_range(0, 4) == 0;
         flush       = $urandom_range(0, 24) == 0;
         fwd_rs_en   = $urandom_range(0, 3) == 0;
         fwd_rt_en   = $urandom_range(0, 3) == 0;
         fwd_rs_data = rdata();
         fwd_rt_data = rdata();
         wb_we       = $urandom_range(0, 1) == 1;
         wb_addr     = 5'($urandom_range(0, 31));
         wb_data     = rdata();
         out_ready   = $urandom_range(0, 3) != 0;
         step(0, 0, 0);
      end

      // reset while stalled and flushing with the pipe busy
      run = 0;
      reset = 1; hz_stall = 1; flush = 1; in_valid = 1; out_ready = 0;
      @(negedge clk);
      #1;
      chk_reset_state();
      clear_model();
      idle();
      reset = 0;
      run = 1;
      for (int n = 0; n < 200; n++) begin
         in_valid  = 1;
         in_instr  = rand_instr();
         in_pc     = $urandom() & 32'hffff_fffc;
         wb_we     = $urandom_range(0, 1) == 1;
         wb_addr   = 5'($urandom_range(0, 31));
         wb_data   = rdata();
         out_ready = $urandom_range(0, 1) == 1;
         step(0, 0, 0);
      end
      idle();
      repeat (4) step(0, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
